// File: rtl/vtc_pkg.sv
// Shared definitions for the video timing controller: axis state encoding,
// runtime-config register addresses and the segment-total helper.
package vtc_pkg;

  typedef enum logic [1:0] {
    AX_ACTIVE = 2'd0,
    AX_FP     = 2'd1,
    AX_SYNC   = 2'd2,
    AX_BP     = 2'd3
  } axis_state_t;

  localparam logic [2:0] CFG_H_ACTIVE = 3'd0;
  localparam logic [2:0] CFG_H_FP     = 3'd1;
  localparam logic [2:0] CFG_H_SYNC   = 3'd2;
  localparam logic [2:0] CFG_H_BP     = 3'd3;
  localparam logic [2:0] CFG_V_ACTIVE = 3'd4;
  localparam logic [2:0] CFG_V_FP     = 3'd5;
  localparam logic [2:0] CFG_V_SYNC   = 3'd6;
  localparam logic [2:0] CFG_V_BP     = 3'd7;

  function automatic logic [31:0] vtc_total(input logic [31:0] a, input logic [31:0] f,
                                             input logic [31:0] s, input logic [31:0] b);
    return a + f + s + b;
  endfunction

endpackage

// File: rtl/vtc_axis.sv
// One raster axis: counts 0..TOTAL-1 and walks ACTIVE -> FP -> SYNC -> BP.
// clr returns the axis to count 0 / ACTIVE and overrides step.
module vtc_axis
  import vtc_pkg::*;
#(
  parameter int unsigned CW = 12
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  input  logic [CW-1:0] len_active,
  input  logic [CW-1:0] len_fp,
  input  logic [CW-1:0] len_sync,
  input  logic [CW-1:0] len_bp,
  output logic [CW-1:0] count,
  output axis_state_t   state,
  output logic          wrap,
  output logic          in_sync
);

  axis_state_t   state_nxt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] end_active, end_fp, end_sync, end_total;
  logic          at_end;

  always_comb begin
    end_active = len_active - CW'(1);
    end_fp     = len_active + len_fp - CW'(1);
    end_sync   = len_active + len_fp + len_sync - CW'(1);
    end_total  = CW'(vtc_total(32'(len_active), 32'(len_fp), 32'(len_sync), 32'(len_bp)) - 32'd1);
  end

  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) begin
      state <= AX_ACTIVE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (clr) begin
      state_nxt = AX_ACTIVE;
      count_nxt = '0;
    end else if (step) begin
      count_nxt = at_end ? '0 : count + CW'(1);
      case (state)
        AX_ACTIVE: if (count == end_active) state_nxt = AX_FP;
        AX_FP:     if (count == end_fp)     state_nxt = AX_SYNC;
        AX_SYNC:   if (count == end_sync)   state_nxt = AX_BP;
        AX_BP:     if (at_end)              state_nxt = AX_ACTIVE;
        default:                            state_nxt = AX_ACTIVE;
      endcase
    end
  end

  always_comb begin
    at_end  = (count == end_total);
    wrap    = step && !clr && at_end;
    in_sync = (state == AX_SYNC);
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: request stage (req/x/y/pulses) plus a PIPE_LAT delay
// line producing de/blank/hsync/vsync. Define VTC_RUNTIME_CFG_EN for runtime timing registers.
module video_timing_ctrl
  import vtc_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned PIPE_LAT  = 2,
  parameter int unsigned CW        = 12
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic          en,
  output logic          req,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          blank,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
`ifdef VTC_RUNTIME_CFG_EN
  ,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_pending
`endif
);

  function automatic logic [CW-1:0] param_len(input logic [2:0] a);
    case (a)
      CFG_H_ACTIVE: return CW'(H_ACTIVE);
      CFG_H_FP:     return CW'(H_FP);
      CFG_H_SYNC:   return CW'(H_SYNC);
      CFG_H_BP:     return CW'(H_BP);
      CFG_V_ACTIVE: return CW'(V_ACTIVE);
      CFG_V_FP:     return CW'(V_FP);
      CFG_V_SYNC:   return CW'(V_SYNC);
      default:      return CW'(V_BP);
    endcase
  endfunction

  logic [CW-1:0] lens [8];
  axis_state_t   h_state, v_state;
  logic          h_wrap, v_wrap, h_in_sync, v_in_sync;
  logic          run, step;
  logic [2:0]    pipe_in, pipe_out;

  // run is en one cycle late so the first enabled cycle presents x=y=0 rather than skipping it
  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= en;
  end

  assign step = en && run;

  vtc_axis #(.CW(CW)) u_h_axis (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .clr       (!en),
    .step      (step),
    .len_active(lens[CFG_H_ACTIVE]),
    .len_fp    (lens[CFG_H_FP]),
    .len_sync  (lens[CFG_H_SYNC]),
    .len_bp    (lens[CFG_H_BP]),
    .count     (x),
    .state     (h_state),
    .wrap      (h_wrap),
    .in_sync   (h_in_sync)
  );

  vtc_axis #(.CW(CW)) u_v_axis (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .clr       (!en),
    .step      (h_wrap),
    .len_active(lens[CFG_V_ACTIVE]),
    .len_fp    (lens[CFG_V_FP]),
    .len_sync  (lens[CFG_V_SYNC]),
    .len_bp    (lens[CFG_V_BP]),
    .count     (y),
    .state     (v_state),
    .wrap      (v_wrap),
    .in_sync   (v_in_sync)
  );

`ifdef VTC_RUNTIME_CFG_EN
  logic [CW-1:0] shadow [8];
  logic          apply;

  assign apply = v_wrap || !en;

  // A write landing on the apply cycle stays pending for the following wrap
  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        shadow[i] <= param_len(3'(i));
        lens[i]   <= param_len(3'(i));
      end
      cfg_pending <= 1'b0;
    end else begin
      if (apply) begin
        for (int unsigned i = 0; i < 8; i++) lens[i] <= shadow[i];
        cfg_pending <= 1'b0;
      end
      if (cfg_wr) begin
        shadow[cfg_addr] <= cfg_data;
        cfg_pending      <= 1'b1;
      end
    end
  end
`else
  logic frame_wrap_unused;
  assign frame_wrap_unused = v_wrap;

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) lens[i] = param_len(3'(i));
  end
`endif

  assign req         = run && (h_state == AX_ACTIVE) && (v_state == AX_ACTIVE);
  assign line_start  = run && (x == '0);
  assign frame_start = line_start && (y == '0);
  assign pipe_in     = {req, run && h_in_sync, run && v_in_sync};

  generate
    if (PIPE_LAT == 0) begin : g_no_lat
      assign pipe_out = pipe_in;
    end else begin : g_lat
      logic [2:0] stage [PIPE_LAT];
      always_ff @(posedge clk_pixel or negedge rst) begin
        if (!rst) begin
          for (int unsigned i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= pipe_in;
          for (int unsigned i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
        end
      end
      assign pipe_out = stage[PIPE_LAT-1];
    end
  endgenerate

  assign de    = pipe_out[2];
  assign blank = ~pipe_out[2];
  assign hsync = pipe_out[1] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync = pipe_out[0] ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl using a reduced raster (25 x 11) so two
// full frames, an enable drop and an asynchronous reset fit in a short run.
module tb_video_timing_ctrl;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int LAT = 2;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        req, de, blank, hsync, vsync, line_start, frame_start;
  logic [11:0] x, y;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk_pixel = ~clk_pixel;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_LAT(LAT), .CW(12)
  ) dut (
    .clk_pixel  (clk_pixel),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .x          (x),
    .y          (y),
    .de         (de),
    .blank      (blank),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Raster position of sample n counted from the first enabled cycle
  function automatic logic m_req(input int n);
    if (n < 0) return 1'b0;
    return ((n % HT) < HA) && (((n / HT) % VT) < VA);
  endfunction

  function automatic logic m_hs(input int n);
    if (n < 0) return 1'b0;
    return ((n % HT) >= HA + HF) && ((n % HT) < HA + HF + HS);
  endfunction

  function automatic logic m_vs(input int n);
    if (n < 0) return 1'b0;
    return (((n / HT) % VT) >= VA + VF) && (((n / HT) % VT) < VA + VF + VS);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  de_cnt, hs_low, vs_low, fs_cnt;
    bit  found;
    de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; found = 1'b0;

    repeat (3) @(negedge clk_pixel);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_req", 32'(req), 0);
    check("rst_de", 32'(de), 0);
    check("rst_blank", 32'(blank), 1);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_ls", 32'(line_start), 0);
    check("rst_fs", 32'(frame_start), 0);

    rst = 1'b1;
    @(negedge clk_pixel);
    check("idle_x", 32'(x), 0);
    check("idle_req", 32'(req), 0);
    check("idle_fs", 32'(frame_start), 0);

    en = 1'b1;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      @(negedge clk_pixel);
      check($sformatf("x@%0d", n), 32'(x), 32'(n % HT));
      check($sformatf("y@%0d", n), 32'(y), 32'((n / HT) % VT));
      check($sformatf("req@%0d", n), 32'(req), 32'(m_req(n)));
      check($sformatf("ls@%0d", n), 32'(line_start), 32'(n % HT == 0));
      check($sformatf("fs@%0d", n), 32'(frame_start), 32'(n % (HT * VT) == 0));
      check($sformatf("de@%0d", n), 32'(de), 32'(m_req(n - LAT)));
      check($sformatf("blank@%0d", n), 32'(blank), 32'(!m_req(n - LAT)));
      check($sformatf("hsync@%0d", n), 32'(hsync), 32'(!m_hs(n - LAT)));
      check($sformatf("vsync@%0d", n), 32'(vsync), 32'(!m_vs(n - LAT)));
      de_cnt += int'(de);
      hs_low += int'(!hsync);
      vs_low += int'(!vsync);
      fs_cnt += int'(frame_start);
    end
    check("de_cycles_2frames", 32'(de_cnt), 32'(2 * HA * VA));
    check("hsync_low_2frames", 32'(hs_low), 32'(2 * VT * HS));
    check("vsync_low_2frames", 32'(vs_low), 32'(2 * VS * HT));
    check("frame_starts", 32'(fs_cnt), 2);

    for (int k = 0; k < 400; k++) begin
      if (x == 12'd7 && y == 12'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_pixel);
    end
    check("reach_x7_y3", 32'(found), 1);

    en = 1'b0;
    @(negedge clk_pixel);
    check("endrop_x", 32'(x), 0);
    check("endrop_y", 32'(y), 0);
    check("endrop_req", 32'(req), 0);
    check("endrop_de_draining", 32'(de), 1);
    repeat (2) @(negedge clk_pixel);
    check("endrop_de_drained", 32'(de), 0);
    check("endrop_blank", 32'(blank), 1);
    check("endrop_hsync", 32'(hsync), 1);
    check("endrop_vsync", 32'(vsync), 1);
    repeat (3) @(negedge clk_pixel);
    check("endrop_hold_x", 32'(x), 0);

    en = 1'b1;
    @(negedge clk_pixel);
    check("enrise_fs", 32'(frame_start), 1);
    check("enrise_ls", 32'(line_start), 1);
    check("enrise_req", 32'(req), 1);
    check("enrise_x", 32'(x), 0);
    check("enrise_de", 32'(de), 0);

    repeat (30) @(negedge clk_pixel);
    check("pre_rst_x", 32'(x), 5);
    check("pre_rst_y", 32'(y), 1);
    check("pre_rst_de", 32'(de), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_req", 32'(req), 0);
    check("arst_de", 32'(de), 0);
    check("arst_blank", 32'(blank), 1);
    check("arst_hsync", 32'(hsync), 1);
    check("arst_vsync", 32'(vsync), 1);

    @(negedge clk_pixel);
    rst = 1'b1;
    @(negedge clk_pixel);
    check("restart_x", 32'(x), 0);
    check("restart_y", 32'(y), 0);
    check("restart_req", 32'(req), 1);
    check("restart_fs", 32'(frame_start), 1);
    @(negedge clk_pixel);
    check("restart_x1", 32'(x), 1);
    check("restart_fs_gone", 32'(frame_start), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
